alu_seq: RTL and testbench
==========================

Name: alu_seq

Overview:
- Parametrised, registered successor to the single-cycle datapath ALU of the multi-cycle CPU.
- Keeps the same operand-source selection (PC or register A; register B, constant step, sign-extended immediate, or immediate<<2).
- Single-cycle ops: ADD, SUB, AND, OR, NOR, SLL, SRL, SRA, SLT.
- Iterative ops: unsigned MUL and unsigned DIV (HI/LO result pair), run under a start/busy/done handshake so the control FSM can stall on them.

Parameters:
- WIDTH, 32: datapath width in bits; must be >= 4 and a power of two.
- STEP, 1: constant selected by alu_src_b=01, used for PC increment.
- SHAMT_W, $clog2(WIDTH): number of shift-amount bits taken from operand 1.

Ports:
- clk  in  1  rising-edge clock
- reset  in  1  synchronous, active-high reset
- start  in  1  launch operation; sampled only in IDLE
- alu_control  in  4  opcode
- alu_src_a  in  1  1: operand1=input_a; 0: operand1=pc
- alu_src_b  in  2  00: input_b; 01: STEP; 10: signextend; 11: signextend<<2
- input_a  in  WIDTH  register A
- input_b  in  WIDTH  register B
- signextend  in  WIDTH  sign-extended immediate
- pc  in  WIDTH  program counter
- busy  out  1  high while an operation is in flight
- done  out  1  one-cycle pulse when results are valid
- alu_result  out  WIDTH  result (LO/quotient for MUL/DIV)
- alu_hi  out  WIDTH  MUL upper half / DIV remainder; 0 for single-cycle ops
- zero  out  1  alu_result==0; updated with done
- overflow  out  1  signed overflow of ADD/SUB; 0 otherwise
- div_zero  out  1  DIV with divisor 0
- illegal_op  out  1  unrecognised opcode

Behaviour:
- Reset: all outputs 0; FSM enters IDLE; internal accumulators cleared. Reset has priority over everything, including mid-operation; an aborted operation produces no done.
- Operand muxes are combinational, but operands are captured into op1_q/op2_q on accepted start. Inputs may change freely after the start cycle.
- Opcodes:
  - 0010 ADD; 0110 SUB; 0000 AND; 0001 OR; 1100 NOR.
  - 1001 SLL: op2 << op1[SHAMT_W-1:0].
  - 1010 SRL; 1011 SRA: same shift-amount rule as SLL.
  - 0111 SLT: signed compare, result 1 or 0.
  - 0100 MULU; 0101 DIVU: op1 / op2.
- FSM states:
  - IDLE: busy=0. If start and the opcode is single-cycle or illegal, go to FIN. If start and MUL/DIV, go to ITER with counter=WIDTH-1.
  - ITER: busy=1. One shift-add (MUL) or restoring subtract-shift (DIV) step per cycle. Go to FIN when counter==0.
  - FIN: busy=1. Write all result registers and flags, pulse done=1, return to IDLE.
- Latency from the start edge to done high:
  - single-cycle ops: 1 cycle
  - MUL/DIV: WIDTH+1 cycles
  - busy is high in every cycle between start and done, inclusive of the done cycle.
- start while busy=1 is ignored and not queued. start in the same cycle as done (FIN) is also ignored; the next start is accepted on the cycle after done.
- Results hold their value until the next done or reset.
- MUL: {alu_hi, alu_result} = 2*WIDTH-bit unsigned product; overflow=0.
- DIV: alu_result=quotient, alu_hi=remainder.
- Divisor 0: alu_result = all ones, alu_hi = op1, div_zero=1, still WIDTH+1 latency.
- ADD/SUB wrap modulo 2^WIDTH. overflow follows the signed rule (operands of equal sign, result of different sign; for SUB, compare against the negated op2).
- Illegal opcode: alu_result=0, alu_hi=0, zero=1, illegal_op=1, 1-cycle latency.
- Flags not produced by the current op are written 0 at done.

Decomposition:
- Package alu_seq_pkg holds:
  - 4-bit opcode localparams (OP_ADD … OP_DIVU)
  - ALU_SRC_B encodings
  - FSM state enum (IDLE, ITER, FIN)
  - an is_multicycle function
- One sub-module, alu_seq_muldiv: iterative shift-add / restoring-divide engine with ports load, mode, op1, op2, step, hi, lo.
- Single-cycle ops and the FSM stay in the top module.

Test Plan:
- Reset sequence:
  - reset high 2 cycles -> all outputs 0.
  - assert reset on cycle 5 of a DIV -> busy=0 next cycle, no done.
- ADD and zero flag (WIDTH=32):
  - alu_src_a=0, pc=0x100, alu_src_b=01 -> done after 1 cycle, result 0x101.
  - ADD 0x7FFFFFFF + 1 -> result 0x80000000, overflow=1.
  - SUB 5-5 -> result 0, zero=1.
- Shifts and compares:
  - SLL input_a=4, input_b=0x3 -> 0x30.
  - SRA input_a=1, input_b=0x80000000 -> 0xC0000000.
  - SLT -1 vs 1 -> 1.
- Branch offset: alu_src_b=11, signextend=0xFFFFFFFF, pc=0x40, ADD -> result 0x3C.
- MULU: 0xFFFFFFFF * 0xFFFFFFFF -> done exactly 33 cycles after start, alu_hi=0xFFFFFFFE, alu_result=0x00000001; a start pulsed mid-operation is ignored.
- DIVU:
  - 100/7 -> quotient 14, remainder 2, 33-cycle latency.
  - 9/0 -> result 0xFFFFFFFF, alu_hi=9, div_zero=1.
  - opcode 1111 -> illegal_op=1.

Source files
------------

// File: rtl/alu_seq_pkg.sv
// Shared definitions for the sequential ALU: opcodes, operand-B source
// encodings, controller states and a helper that classifies opcodes.
package alu_seq_pkg;

    localparam logic [3:0] OP_AND  = 4'b0000;
    localparam logic [3:0] OP_OR   = 4'b0001;
    localparam logic [3:0] OP_ADD  = 4'b0010;
    localparam logic [3:0] OP_MULU = 4'b0100;
    localparam logic [3:0] OP_DIVU = 4'b0101;
    localparam logic [3:0] OP_SUB  = 4'b0110;
    localparam logic [3:0] OP_SLT  = 4'b0111;
    localparam logic [3:0] OP_SLL  = 4'b1001;
    localparam logic [3:0] OP_SRL  = 4'b1010;
    localparam logic [3:0] OP_SRA  = 4'b1011;
    localparam logic [3:0] OP_NOR  = 4'b1100;

    localparam logic [1:0] SRC_B_REG    = 2'b00;
    localparam logic [1:0] SRC_B_STEP   = 2'b01;
    localparam logic [1:0] SRC_B_IMM    = 2'b10;
    localparam logic [1:0] SRC_B_IMM_X4 = 2'b11;

    typedef enum logic [1:0] {
        IDLE,
        ITER,
        FIN
    } state_t;

    // MUL and DIV are the only opcodes that need the iterative engine.
    function automatic logic is_multicycle(input logic [3:0] op);
        return (op == OP_MULU) || (op == OP_DIVU);
    endfunction

endpackage

// File: rtl/alu_seq_muldiv.sv
// Iterative unsigned multiply / divide engine. One bit per step:
// shift-add for multiply, restoring subtract-shift for divide.
// After WIDTH steps {hi, lo} holds the product, or remainder/quotient.
module alu_seq_muldiv
    import alu_seq_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             load,
    input  logic             mode,
    input  logic [WIDTH-1:0] op1,
    input  logic [WIDTH-1:0] op2,
    input  logic             step,
    output logic [WIDTH-1:0] hi,
    output logic [WIDTH-1:0] lo
);

    logic [WIDTH-1:0] hi_q, lo_q, den_q;
    logic             mode_q;
    logic [WIDTH:0]   mul_sum;
    logic [WIDTH:0]   div_shift;
    logic             div_ge;
    logic [WIDTH-1:0] div_rem;

    // Datapath for one step: the multiplier adds the multiplicand when the
    // current multiplier bit is set; the divider pulls in the next dividend
    // bit and trial-subtracts the divisor. A zero divisor always "fits",
    // which leaves all-ones in the quotient and the dividend in hi.
    always_comb begin
        mul_sum   = {1'b0, hi_q} + (lo_q[0] ? {1'b0, den_q} : '0);
        div_shift = {hi_q, lo_q[WIDTH-1]};
        div_ge    = (div_shift >= {1'b0, den_q});
        div_rem   = div_shift[WIDTH-1:0] - den_q;
    end

    // Accumulators: load clears hi and seeds lo with op1, then each step
    // shifts one bit of work through the {hi, lo} pair.
    always_ff @(posedge clk) begin
        if (reset) begin
            hi_q   <= '0;
            lo_q   <= '0;
            den_q  <= '0;
            mode_q <= 1'b0;
        end else if (load) begin
            hi_q   <= '0;
            lo_q   <= op1;
            den_q  <= op2;
            mode_q <= mode;
        end else if (step) begin
            if (mode_q) begin
                if (div_ge) begin
                    hi_q <= div_rem;
                    lo_q <= {lo_q[WIDTH-2:0], 1'b1};
                end else begin
                    hi_q <= div_shift[WIDTH-1:0];
                    lo_q <= {lo_q[WIDTH-2:0], 1'b0};
                end
            end else begin
                hi_q <= mul_sum[WIDTH:1];
                lo_q <= {mul_sum[0], lo_q[WIDTH-1:1]};
            end
        end
    end

    assign hi = hi_q;
    assign lo = lo_q;

endmodule

// File: rtl/alu_seq.sv
// Registered ALU for the multi-cycle CPU. Single-cycle ops finish one cycle
// after start; MUL/DIV run through the iterative engine. Results and flags
// are presented during the done cycle and held until the next done.
module alu_seq
    import alu_seq_pkg::*;
#(
    parameter int WIDTH   = 32,
    parameter int STEP    = 1,
    parameter int SHAMT_W = $clog2(WIDTH)
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [3:0]       alu_control,
    input  logic             alu_src_a,
    input  logic [1:0]       alu_src_b,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic [WIDTH-1:0] signextend,
    input  logic [WIDTH-1:0] pc,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] alu_result,
    output logic [WIDTH-1:0] alu_hi,
    output logic             zero,
    output logic             overflow,
    output logic             div_zero,
    output logic             illegal_op
);

    localparam int CNT_W = $clog2(WIDTH);

    state_t             state_q, state_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]   op1, op2, op1_q, op2_q;
    logic [3:0]         opc_q;
    logic               accept, md_load;
    logic [WIDTH-1:0]   md_hi, md_lo;
    logic [WIDTH-1:0]   sum, diff;
    logic [SHAMT_W-1:0] shamt;
    logic [WIDTH-1:0]   res_d, res_q, hi_d, hi_q;
    logic               zero_d, zero_q, ovf_d, ovf_q, dz_d, dz_q, ill_d, ill_q;

    // Operand selection, identical to the old single-cycle ALU.
    always_comb begin
        op1 = alu_src_a ? input_a : pc;
        case (alu_src_b)
            SRC_B_REG:    op2 = input_b;
            SRC_B_STEP:   op2 = WIDTH'(STEP);
            SRC_B_IMM:    op2 = signextend;
            default:      op2 = signextend << 2;
        endcase
    end

    // Controller: start is only honoured in IDLE, so pulses during busy or
    // during the done cycle are dropped. MUL/DIV load the engine on accept.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        busy    = 1'b0;
        done    = 1'b0;
        accept  = 1'b0;
        md_load = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    accept  = 1'b1;
                    md_load = is_multicycle(alu_control);
                    cnt_d   = CNT_W'(WIDTH - 1);
                    state_d = md_load ? ITER : FIN;
                end
            end
            ITER: begin
                busy = 1'b1;
                if (cnt_q == '0) begin
                    state_d = FIN;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            FIN: begin
                busy    = 1'b1;
                done    = 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    // State and step counter; reset aborts any operation in flight.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    // Operands and opcode are frozen on accept so the CPU may move on.
    always_ff @(posedge clk) begin
        if (reset) begin
            op1_q <= '0;
            op2_q <= '0;
            opc_q <= '0;
        end else if (accept) begin
            op1_q <= op1;
            op2_q <= op2;
            opc_q <= alu_control;
        end
    end

    alu_seq_muldiv #(.WIDTH(WIDTH)) u_muldiv (
        .clk   (clk),
        .reset (reset),
        .load  (md_load),
        .mode  (alu_control == OP_DIVU),
        .op1   (op1),
        .op2   (op2),
        .step  (state_q == ITER),
        .hi    (md_hi),
        .lo    (md_lo)
    );

    assign sum   = op1_q + op2_q;
    assign diff  = op1_q - op2_q;
    assign shamt = op1_q[SHAMT_W-1:0];

    // Result and flag values for the captured op; flags the op does not
    // produce stay 0, and illegal opcodes report a zero result.
    always_comb begin
        res_d = '0;
        hi_d  = '0;
        ovf_d = 1'b0;
        dz_d  = 1'b0;
        ill_d = 1'b0;
        case (opc_q)
            OP_ADD: begin
                res_d = sum;
                ovf_d = (op1_q[WIDTH-1] == op2_q[WIDTH-1]) && (sum[WIDTH-1] != op1_q[WIDTH-1]);
            end
            OP_SUB: begin
                res_d = diff;
                ovf_d = (op1_q[WIDTH-1] != op2_q[WIDTH-1]) && (diff[WIDTH-1] != op1_q[WIDTH-1]);
            end
            OP_AND:  res_d = op1_q & op2_q;
            OP_OR:   res_d = op1_q | op2_q;
            OP_NOR:  res_d = ~(op1_q | op2_q);
            OP_SLL:  res_d = op2_q << shamt;
            OP_SRL:  res_d = op2_q >> shamt;
            OP_SRA:  res_d = $signed(op2_q) >>> shamt;
            OP_SLT:  res_d = {{(WIDTH-1){1'b0}}, $signed(op1_q) < $signed(op2_q)};
            OP_MULU: begin
                res_d = md_lo;
                hi_d  = md_hi;
            end
            OP_DIVU: begin
                if (op2_q == '0) begin
                    res_d = '1;
                    hi_d  = op1_q;
                    dz_d  = 1'b1;
                end else begin
                    res_d = md_lo;
                    hi_d  = md_hi;
                end
            end
            default: ill_d = 1'b1;
        endcase
        zero_d = (res_d == '0);
    end

    // Result registers latch at the end of the done cycle so values persist
    // until the next done.
    always_ff @(posedge clk) begin
        if (reset) begin
            res_q  <= '0;
            hi_q   <= '0;
            zero_q <= 1'b0;
            ovf_q  <= 1'b0;
            dz_q   <= 1'b0;
            ill_q  <= 1'b0;
        end else if (state_q == FIN) begin
            res_q  <= res_d;
            hi_q   <= hi_d;
            zero_q <= zero_d;
            ovf_q  <= ovf_d;
            dz_q   <= dz_d;
            ill_q  <= ill_d;
        end
    end

    // Outputs show fresh values during done, held values otherwise.
    always_comb begin
        if (state_q == FIN) begin
            alu_result = res_d;
            alu_hi     = hi_d;
            zero       = zero_d;
            overflow   = ovf_d;
            div_zero   = dz_d;
            illegal_op = ill_d;
        end else begin
            alu_result = res_q;
            alu_hi     = hi_q;
            zero       = zero_q;
            overflow   = ovf_q;
            div_zero   = dz_q;
            illegal_op = ill_q;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Directed bench for alu_seq at WIDTH=32 with hand-computed expectations.
module tb_alu_seq;

    localparam logic [3:0] ADD  = 4'b0010;
    localparam logic [3:0] SUB  = 4'b0110;
    localparam logic [3:0] SLL  = 4'b1001;
    localparam logic [3:0] SRA  = 4'b1011;
    localparam logic [3:0] SLT  = 4'b0111;
    localparam logic [3:0] MULU = 4'b0100;
    localparam logic [3:0] DIVU = 4'b0101;
    localparam logic [3:0] BAD  = 4'b1111;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        start = 1'b0;
    logic [3:0]  alu_control = '0;
    logic        alu_src_a = 1'b1;
    logic [1:0]  alu_src_b = '0;
    logic [31:0] input_a = '0, input_b = '0, signextend = '0, pc = '0;
    logic        busy, done, zero, overflow, div_zero, illegal_op;
    logic [31:0] alu_result, alu_hi;

    int checks = 0;
    int errors = 0;
    int lat;
    logic sawDone;

    alu_seq dut (
        .clk         (clk),
        .reset       (reset),
        .start       (start),
        .alu_control (alu_control),
        .alu_src_a   (alu_src_a),
        .alu_src_b   (alu_src_b),
        .input_a     (input_a),
        .input_b     (input_b),
        .signextend  (signextend),
        .pc          (pc),
        .busy        (busy),
        .done        (done),
        .alu_result  (alu_result),
        .alu_hi      (alu_hi),
        .zero        (zero),
        .overflow    (overflow),
        .div_zero    (div_zero),
        .illegal_op  (illegal_op)
    );

    // Free-running 10-time-unit clock.
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // Drives one operation, pulses start for the accepting edge and waits
    // (bounded) for done. lat counts cycles from the start edge to done.
    // A non-zero pokeAt re-pulses start with ADD in that busy cycle.
    task automatic applyStimulus(input logic [3:0] ctl, input logic srcA, input logic [1:0] srcB,
                                 input logic [31:0] a, input logic [31:0] b,
                                 input logic [31:0] se, input logic [31:0] pcv,
                                 input int pokeAt, output int latOut);
        @(posedge clk); #1;
        alu_control = ctl;
        alu_src_a   = srcA;
        alu_src_b   = srcB;
        input_a     = a;
        input_b     = b;
        signextend  = se;
        pc          = pcv;
        start       = 1'b1;
        @(posedge clk); #1;
        start  = 1'b0;
        input_a = 32'hDEAD_BEEF;
        input_b = 32'h1234_5678;
        latOut = 1;
        while (!done && latOut < 100) begin
            if (latOut == pokeAt) begin
                alu_control = ADD;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            @(posedge clk); #1;
            latOut++;
        end
        start = 1'b0;
    endtask

    function automatic logic [31:0] flags();
        return {28'd0, zero, overflow, div_zero, illegal_op};
    endfunction

    initial begin
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rstResult", alu_result, 32'h0);
        checkOutput("rstHi", alu_hi, 32'h0);
        checkOutput("rstCtl", {30'd0, busy, done}, 32'h0);
        checkOutput("rstFlags", flags(), 32'h0);
        reset = 1'b0;

        applyStimulus(ADD, 1'b0, 2'b01, 32'h0, 32'h0, 32'h0, 32'h100, 0, lat);
        checkOutput("pcIncLat", lat, 1);
        checkOutput("pcIncRes", alu_result, 32'h101);

        applyStimulus(ADD, 1'b1, 2'b00, 32'h7FFF_FFFF, 32'h1, 32'h0, 32'h0, 0, lat);
        checkOutput("addOvfRes", alu_result, 32'h8000_0000);
        checkOutput("addOvfFlags", flags(), 32'b0100);

        applyStimulus(SUB, 1'b1, 2'b00, 32'h5, 32'h5, 32'h0, 32'h0, 0, lat);
        checkOutput("subZeroRes", alu_result, 32'h0);
        checkOutput("subZeroFlags", flags(), 32'b1000);

        applyStimulus(SUB, 1'b1, 2'b00, 32'h8000_0000, 32'h1, 32'h0, 32'h0, 0, lat);
        checkOutput("subOvfRes", alu_result, 32'h7FFF_FFFF);
        checkOutput("subOvfFlags", flags(), 32'b0100);

        applyStimulus(SLL, 1'b1, 2'b00, 32'h4, 32'h3, 32'h0, 32'h0, 0, lat);
        checkOutput("sllRes", alu_result, 32'h30);

        applyStimulus(SRA, 1'b1, 2'b00, 32'h1, 32'h8000_0000, 32'h0, 32'h0, 0, lat);
        checkOutput("sraRes", alu_result, 32'hC000_0000);

        applyStimulus(SLT, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'h1, 32'h0, 32'h0, 0, lat);
        checkOutput("sltRes", alu_result, 32'h1);

        applyStimulus(ADD, 1'b0, 2'b11, 32'h0, 32'h0, 32'hFFFF_FFFF, 32'h40, 0, lat);
        checkOutput("branchRes", alu_result, 32'h3C);

        applyStimulus(MULU, 1'b1, 2'b00, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0, 32'h0, 10, lat);
        checkOutput("mulLat", lat, 33);
        checkOutput("mulHi", alu_hi, 32'hFFFF_FFFE);
        checkOutput("mulLo", alu_result, 32'h0000_0001);
        checkOutput("mulFlags", flags(), 32'b0000);

        @(posedge clk); #1;
        @(posedge clk); #1;
        checkOutput("holdRes", alu_result, 32'h0000_0001);
        checkOutput("holdCtl", {30'd0, busy, done}, 32'h0);

        applyStimulus(ADD, 1'b1, 2'b00, 32'h2, 32'h3, 32'h0, 32'h0, 0, lat);
        checkOutput("addAfterMulHi", alu_hi, 32'h0);
        checkOutput("addAfterMulRes", alu_result, 32'h5);

        applyStimulus(DIVU, 1'b1, 2'b00, 32'd100, 32'd7, 32'h0, 32'h0, 0, lat);
        checkOutput("divLat", lat, 33);
        checkOutput("divQuot", alu_result, 32'd14);
        checkOutput("divRem", alu_hi, 32'd2);

        applyStimulus(DIVU, 1'b1, 2'b00, 32'd9, 32'd0, 32'h0, 32'h0, 0, lat);
        checkOutput("div0Lat", lat, 33);
        checkOutput("div0Res", alu_result, 32'hFFFF_FFFF);
        checkOutput("div0Hi", alu_hi, 32'd9);
        checkOutput("div0Flags", flags(), 32'b0010);

        applyStimulus(BAD, 1'b1, 2'b00, 32'h5, 32'h6, 32'h0, 32'h0, 0, lat);
        checkOutput("illLat", lat, 1);
        checkOutput("illRes", alu_result, 32'h0);
        checkOutput("illFlags", flags(), 32'b1001);

        // Reset in cycle 5 of a DIV: busy drops, no done ever appears.
        applyStimulus(DIVU, 1'b1, 2'b00, 32'd100, 32'd7, 32'h0, 32'h0, 0, lat);
        @(posedge clk); #1;
        alu_control = DIVU;
        input_a = 32'd50;
        input_b = 32'd3;
        start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
        repeat (4) @(posedge clk);
        #1;
        reset = 1'b1;
        @(posedge clk); #1;
        checkOutput("abortCtl", {30'd0, busy, done}, 32'h0);
        checkOutput("abortRes", alu_result, 32'h0);
        reset = 1'b0;
        sawDone = 1'b0;
        repeat (40) begin
            @(posedge clk); #1;
            if (done) sawDone = 1'b1;
        end
        checkOutput("abortNoDone", {31'd0, sawDone}, 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
